// File: rtl/mop_queue_pkg.sv
// mop_queue_pkg
//   Shared types for the micro-op queue that sits between the micro-op
//   cracker and rename/issue.
//   - MAX_MOP_CNT   : most micro-ops one instruction can crack into
//   - micro_op_t    : one cracked micro-op
//   - mop_q_entry_t : one queue entry, a micro-op plus its end-of-instruction tag
//   - mop_cnt_is_write : true when a cracked count actually writes entries
package mop_queue_pkg;

  localparam int MAX_MOP_CNT = 4;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } micro_op_t;

  typedef struct packed {
    micro_op_t mop;
    logic      eoi;
  } mop_q_entry_t;

  // A count of zero is a legal no-op, and counts above MAX_MOP_CNT are
  // illegal. Only counts in between write entries into the queue.
  function automatic logic mop_cnt_is_write(input logic [2:0] cnt);
    return (cnt != 3'd0) && (int'(cnt) <= MAX_MOP_CNT);
  endfunction

endpackage

// File: rtl/mop_queue.sv
// mop_queue
//   Circular micro-op buffer. It accepts one whole cracked instruction per
//   cycle, which is 0..MAX_MOP_CNT micro-ops written all at once. It issues
//   one micro-op per cycle in program order. The last micro-op of each
//   instruction carries eoi so that retirement can find instruction
//   boundaries.
// Ports
//   clk, reset        clock; synchronous active-high reset
//   flush             drop every buffered micro-op (takes effect next cycle)
//   in_valid/in_ready producer handshake. in_ready means at least
//                     MAX_MOP_CNT entries are free.
//   in_cnt, in_mops   micro-op count and slots. Slot 0 is the oldest.
//   out_valid/out_ready consumer handshake on the head entry
//   out_mop, out_eoi  head micro-op and its end-of-instruction tag
//   count             current occupancy
//   err               one-cycle pulse after an illegal in_cnt is accepted
module mop_queue
  import mop_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2:0]                           in_cnt,
  input  micro_op_t [0:MAX_MOP_CNT-1]          in_mops,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output micro_op_t                            out_mop,
  output logic                                 out_eoi,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mop_q_entry_t           entries [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;

  logic                   accept;
  logic                   wr_fire;
  logic                   bad_cnt;
  logic                   rd_fire;
  logic [2:0]             wr_cnt;

  // Handshake decode. in_ready comes only from the registered count. A read
  // in the same cycle therefore never opens the door for a write. This keeps
  // in_ready off any combinational path from the consumer.
  assign in_ready  = (count <= CNT_W'(DEPTH - MAX_MOP_CNT));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign wr_fire   = accept & mop_cnt_is_write(in_cnt);
  assign bad_cnt   = accept & (int'(in_cnt) > MAX_MOP_CNT);
  assign rd_fire   = out_valid & out_ready;
  assign wr_cnt    = wr_fire ? in_cnt : 3'd0;

  // The head entry drives the outputs directly. A micro-op written this
  // cycle becomes visible only after the clock edge, so there is no bypass.
  assign out_mop = entries[head].mop;
  assign out_eoi = entries[head].eoi;

  // Pointer and occupancy bookkeeping. Flush wins over any write, read or
  // error in the same cycle. The pointers return to zero, and the stale
  // entry contents become unreachable.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      err <= bad_cnt;
      if (wr_fire) begin
        tail <= tail + PTR_W'(wr_cnt);
      end
      if (rd_fire) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_cnt) - CNT_W'(rd_fire);
    end
  end

  // Multi-port write of one whole instruction. Slot i goes to tail+i, and
  // the pointer addition wraps naturally because DEPTH is a power of two.
  // Only the final slot is tagged eoi, so the queue never holds a partial
  // instruction boundary. The data flops need no reset, because occupancy
  // alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_fire) begin
      for (int i = 0; i < MAX_MOP_CNT; i++) begin
        if (3'(i) < in_cnt) begin
          entries[tail + PTR_W'(i)].mop <= in_mops[i];
          entries[tail + PTR_W'(i)].eoi <= (3'(i) == (in_cnt - 3'd1));
        end
      end
    end
  end

endmodule

// File: tb/tb_mop_queue.sv
// tb_mop_queue
//   Self-checking bench for mop_queue. A reference queue of micro-ops models
//   the buffer at the instruction level. Directed scenarios compare against
//   hand-derived constants. The random scenario compares every cycle against
//   the reference queue.
module tb_mop_queue;
  import mop_queue_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    micro_op_t mop;
    bit        eoi;
  } ref_entry_t;

  logic                        clk;
  logic                        reset;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  in_cnt;
  micro_op_t [0:MAX_MOP_CNT-1] in_mops;
  logic                        out_valid;
  logic                        out_ready;
  micro_op_t                   out_mop;
  logic                        out_eoi;
  logic [$clog2(DEPTH):0]      count;
  logic                        err;

  ref_entry_t mq[$];
  bit         exp_err;
  int         total;
  int         bad;

  mop_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_mops   (in_mops),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mop   (out_mop),
    .out_eoi   (out_eoi),
    .count     (count),
    .err       (err)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns a random micro-op.
  function automatic micro_op_t rand_mop();
    logic [31:0] r;
    r = $urandom();
    return r[$bits(micro_op_t)-1:0];
  endfunction

  // Fills every input slot with a random micro-op.
  task automatic fill_random_mops();
    for (int i = 0; i < MAX_MOP_CNT; i++) in_mops[i] = rand_mop();
  endtask

  // Applies one clock edge with the current inputs and advances the
  // reference queue. The model is written from the queue rules alone: an
  // instruction is accepted when there is room for a full instruction, and
  // the consumer pops the oldest micro-op.
  task automatic do_cycle();
    bit room;
    bit acc;
    bit rd;
    room = (DEPTH - mq.size()) >= MAX_MOP_CNT;
    acc  = in_valid && room;
    rd   = (mq.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    if (reset || flush) begin
      mq.delete();
      exp_err = 1'b0;
    end else begin
      if (rd) void'(mq.pop_front());
      if (acc && in_cnt >= 3'd1 && in_cnt <= 3'd4) begin
        for (int i = 0; i < int'(in_cnt); i++) begin
          ref_entry_t e;
          e.mop = in_mops[i];
          e.eoi = (i == int'(in_cnt) - 1);
          mq.push_back(e);
        end
      end
      exp_err = acc && (in_cnt > 3'd4);
    end
  endtask

  // Drains the queue with out_ready held high and compares every issued
  // micro-op against the reference. The drain is bounded by a cycle limit.
  task automatic drain_and_compare(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && out_valid; k++) begin
      total++;
      if (mq.size() == 0 || out_mop !== mq[0].mop || out_eoi !== mq[0].eoi) begin
        bad++;
        $display("[TB] FAIL %s_drain got=%h/%0d want_size=%0d", tag, out_mop, out_eoi, mq.size());
      end
      do_cycle();
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain_empty got=%0b want=0 model=%0d", tag, out_valid, mq.size());
    end
  endtask

  // Checks the idle state after two cycles of reset.
  task automatic test_reset();
    reset = 1'b1;
    do_cycle();
    do_cycle();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (count !== 5'd0)     begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (err !== 1'b0)       begin bad++; $display("[TB] FAIL reset_err got=%0b want=0", err); end
  endtask

  // Writes a single 3-micro-op instruction and checks its order and eoi.
  task automatic test_basic();
    micro_op_t abc [3];
    for (int i = 0; i < 3; i++) abc[i] = rand_mop();
    in_valid = 1'b1;
    in_cnt   = 3'd3;
    for (int i = 0; i < 3; i++) in_mops[i] = abc[i];
    in_mops[3] = rand_mop();
    out_ready = 1'b0;
    do_cycle();
    in_valid = 1'b0;
    total++; if (count !== 5'd3)     begin bad++; $display("[TB] FAIL basic_count got=%0d want=3", count); end
    total++; if (out_mop !== abc[0]) begin bad++; $display("[TB] FAIL basic_head got=%h want=%h", out_mop, abc[0]); end
    total++; if (out_eoi !== 1'b0)   begin bad++; $display("[TB] FAIL basic_head_eoi got=%0b want=0", out_eoi); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_mop !== abc[k] || out_eoi !== (k == 2)) begin
        bad++;
        $display("[TB] FAIL basic_issue%0d got=%0b/%h/%0b want=1/%h/%0b", k, out_valid, out_mop, out_eoi, abc[k], (k == 2));
      end
      do_cycle();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_empty got=%0b want=0", out_valid); end
  endtask

  // Fills the queue with four full instructions. A held fifth instruction
  // must wait until reads bring the count back down to 12.
  task automatic test_full();
    int exp_cnt [5] = '{15, 14, 13, 12, 15};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cnt    = 3'd4;
    for (int g = 0; g < 4; g++) begin
      fill_random_mops();
      do_cycle();
      total++;
      if (count !== 5'(4 * (g + 1)) || in_ready !== (g < 3)) begin
        bad++;
        $display("[TB] FAIL full_fill%0d got=%0d/%0b want=%0d/%0b", g, count, in_ready, 4 * (g + 1), (g < 3));
      end
    end
    fill_random_mops();
    do_cycle();
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL full_held got=%0d want=16", count); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (mq.size() == 0 || out_mop !== mq[0].mop) begin
        bad++;
        $display("[TB] FAIL full_order%0d got=%h", k, out_mop);
      end
      do_cycle();
      total++;
      if (count !== 5'(exp_cnt[k])) begin
        bad++;
        $display("[TB] FAIL full_count%0d got=%0d want=%0d", k, count, exp_cnt[k]);
      end
      if (k == 2) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_at13 got=%0b want=0", in_ready); end
      end
    end
    drain_and_compare("full");
  endtask

  // A write and a read in the same cycle, starting from a count of 8.
  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cnt    = 3'd4;
    fill_random_mops(); do_cycle();
    fill_random_mops(); do_cycle();
    total++; if (count !== 5'd8) begin bad++; $display("[TB] FAIL b2b_setup got=%0d want=8", count); end
    in_cnt    = 3'd2;
    out_ready = 1'b1;
    fill_random_mops();
    do_cycle();
    total++; if (count !== 5'd9) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=9", count); end
    drain_and_compare("b2b");
  endtask

  // Random groups with random consumer stalls, over enough cycles for the
  // pointers to wrap many times.
  task automatic test_wrap();
    int pushed;
    pushed = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_cnt    = 3'($urandom_range(0, 4));
      out_ready = ($urandom_range(0, 1) == 1);
      fill_random_mops();
      if (in_valid && (DEPTH - mq.size()) >= MAX_MOP_CNT) pushed += int'(in_cnt);
      do_cycle();
      total++;
      if (count !== 5'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== ((DEPTH - mq.size()) >= MAX_MOP_CNT) || err !== exp_err) begin
        bad++;
        $display("[TB] FAIL wrap_state%0d got=%0d/%0b/%0b/%0b want_count=%0d", c, count, out_valid, in_ready, err, mq.size());
      end
      if (mq.size() != 0) begin
        total++;
        if (out_mop !== mq[0].mop || out_eoi !== mq[0].eoi) begin
          bad++;
          $display("[TB] FAIL wrap_head%0d got=%h/%0b want=%h/%0b", c, out_mop, out_eoi, mq[0].mop, mq[0].eoi);
        end
      end
    end
    total++;
    if (pushed < 3 * DEPTH) begin bad++; $display("[TB] FAIL wrap_traffic got=%0d want>=%0d", pushed, 3 * DEPTH); end
    drain_and_compare("wrap");
  endtask

  // Flush against a simultaneous write and read, then the legal no-op count
  // and the illegal count.
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cnt    = 3'd4; fill_random_mops(); do_cycle();
    in_cnt    = 3'd3; fill_random_mops(); do_cycle();
    total++; if (count !== 5'd7) begin bad++; $display("[TB] FAIL flush_setup got=%0d want=7", count); end
    flush     = 1'b1;
    in_cnt    = 3'd4;
    out_ready = 1'b1;
    fill_random_mops();
    do_cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (count !== 5'd0)     begin bad++; $display("[TB] FAIL flush_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%0b want=0", out_valid); end
    total++; if (err !== 1'b0)       begin bad++; $display("[TB] FAIL flush_err got=%0b want=0", err); end
    in_valid = 1'b1; in_cnt = 3'd2; fill_random_mops(); do_cycle();
    in_cnt = 3'd0; do_cycle();
    total++; if (count !== 5'd2 || err !== 1'b0) begin bad++; $display("[TB] FAIL nop_cnt0 got=%0d/%0b want=2/0", count, err); end
    in_cnt = 3'd6; do_cycle();
    in_valid = 1'b0;
    total++; if (count !== 5'd2 || err !== 1'b1) begin bad++; $display("[TB] FAIL bad_cnt got=%0d/%0b want=2/1", count, err); end
    do_cycle();
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL bad_cnt_pulse got=%0b want=0", err); end
    drain_and_compare("flush");
  endtask

  // Runs each scenario in order, then prints the single summary line.
  initial begin
    total     = 0;
    bad       = 0;
    exp_err   = 1'b0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_cnt    = 3'd0;
    out_ready = 1'b0;
    for (int i = 0; i < MAX_MOP_CNT; i++) in_mops[i] = '0;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
